sparse_index_merger: RTL and testbench

//  Upstream feeder for the fp16 multiplier in the sparse matrix coprocessor.

---
 rtl/sparse_index_merger_pkg.sv | 25 ++
 rtl/sparse_index_merger_pair_out_reg.sv | 37 +++
 rtl/sparse_index_merger.sv | 195 +++++++++++++++++++
 tb/tb_sparse_index_merger.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_index_merger_pkg.sv
// Shared types and constants for the sparse index merger and its neighbours.
package sparse_index_merger_pkg;

  localparam int SP_IDX_W  = 4;
  localparam int SP_DATA_W = 16;
  localparam int SP_CNT_W  = 5;

  typedef logic [15:0] fp16_t;

  typedef struct packed {
    logic [SP_IDX_W-1:0] index;
    fp16_t               data;
    logic                last;
  } sp_elem_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH_A,
    ST_FLUSH_B,
    ST_DRAIN,
    ST_DONE
  } merge_state_e;

endpackage

// File: rtl/sparse_index_merger_pair_out_reg.sv
// One-entry valid/ready output register. It supports load, hold and
// pass-through (load while the current entry drains in the same cycle).
// The producer must only load when free_o is high.
module sparse_index_merger_pair_out_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         free_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign free_o  = !valid_q || ready_i;

  // Entry register: load takes priority over drain so pass-through works.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/sparse_index_merger.sv
// Walks two index-sorted sparse vectors in lockstep and forwards only the
// index-matched value pairs to the fp16 multiplier.
//
// state    | meaning
// IDLE     | waiting for start
// RUN      | both streams live, comparing heads
// FLUSH_A  | B has ended, discard the rest of A
// FLUSH_B  | A has ended, discard the rest of B
// DRAIN    | streams consumed, waiting for the last pair to leave
// DONE     | one-cycle done pulse
module sparse_index_merger
  import sparse_index_merger_pkg::*;
#(
  parameter int IDX_W  = SP_IDX_W,
  parameter int DATA_W = SP_DATA_W,
  parameter int CNT_W  = SP_CNT_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [IDX_W-1:0]  a_index_i,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic              a_last_i,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic [IDX_W-1:0]  b_index_i,
  input  logic [DATA_W-1:0] b_data_i,
  input  logic              b_last_i,
  output logic              p_valid_o,
  input  logic              p_ready_i,
  output logic [DATA_W-1:0] p_dataa_o,
  output logic [DATA_W-1:0] p_datab_o,
  output logic [IDX_W-1:0]  p_index_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  match_count_o,
  output logic              err_o
);

  localparam int PAIR_W = IDX_W + 2 * DATA_W;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(2 ** IDX_W);

  merge_state_e      state_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [CNT_W-1:0]  match_count_q;
  logic [IDX_W-1:0]  last_a_q;
  logic [IDX_W-1:0]  last_b_q;
  logic              have_a_q;
  logic              have_b_q;

  logic              a_pop_d;
  logic              b_pop_d;
  logic              load_d;
  logic              out_free;
  logic [PAIR_W-1:0] pair_in;
  logic [PAIR_W-1:0] pair_out;

  // Pop decisions depend on the current heads, so the readies are combinational.
  always_comb begin
    a_pop_d = 1'b0;
    b_pop_d = 1'b0;
    load_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (a_valid_i && b_valid_i) begin
          if (a_index_i < b_index_i) begin
            a_pop_d = 1'b1;
          end else if (a_index_i > b_index_i) begin
            b_pop_d = 1'b1;
          end else if (out_free) begin
            a_pop_d = 1'b1;
            b_pop_d = 1'b1;
            load_d  = 1'b1;
          end
        end
      end
      ST_FLUSH_A: a_pop_d = a_valid_i;
      ST_FLUSH_B: b_pop_d = b_valid_i;
      default: ;
    endcase
  end

  assign a_ready_o = a_pop_d;
  assign b_ready_o = b_pop_d;
  assign pair_in   = {a_index_i, a_data_i, b_data_i};

  sparse_index_merger_pair_out_reg #(
    .W (PAIR_W)
  ) u_pair_out (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (load_d),
    .data_i  (pair_in),
    .ready_i (p_ready_i),
    .valid_o (p_valid_o),
    .data_o  (pair_out),
    .free_o  (out_free)
  );

  assign {p_index_o, p_dataa_o, p_datab_o} = pair_out;

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign match_count_o = match_count_q;
  assign err_o         = err_q;

  // Merge sequencing, registered status outputs and per-stream order check.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      match_count_q <= '0;
      last_a_q      <= '0;
      last_b_q      <= '0;
      have_a_q      <= 1'b0;
      have_b_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q       <= ST_RUN;
            busy_q        <= 1'b1;
            match_count_q <= '0;
            err_q         <= 1'b0;
            have_a_q      <= 1'b0;
            have_b_q      <= 1'b0;
          end
        end
        ST_RUN: begin
          if (load_d) begin
            if (match_count_q != MAX_CNT) begin
              match_count_q <= match_count_q + 1'b1;
            end
            if (a_last_i && b_last_i) begin
              state_q <= ST_DRAIN;
            end else if (a_last_i) begin
              state_q <= ST_FLUSH_B;
            end else if (b_last_i) begin
              state_q <= ST_FLUSH_A;
            end
          end else if (a_pop_d && a_last_i) begin
            state_q <= ST_FLUSH_B;
          end else if (b_pop_d && b_last_i) begin
            state_q <= ST_FLUSH_A;
          end
        end
        ST_FLUSH_A: begin
          if (a_pop_d && a_last_i) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_FLUSH_B: begin
          if (b_pop_d && b_last_i) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_free) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase

      // Pops never happen in IDLE, so this cannot race the clear on start.
      if (a_pop_d) begin
        have_a_q <= 1'b1;
        last_a_q <= a_index_i;
        if (have_a_q && (a_index_i <= last_a_q)) begin
          err_q <= 1'b1;
        end
      end
      if (b_pop_d) begin
        have_b_q <= 1'b1;
        last_b_q <= b_index_i;
        if (have_b_q && (b_index_i <= last_b_q)) begin
          err_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sparse_index_merger.sv
// Scoreboard bench for sparse_index_merger: stream drivers, a pair monitor
// and a set-intersection reference model.
module tb_sparse_index_merger;

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] data;
  } el_t;

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] da;
    logic [15:0] db;
  } pair_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        a_valid, a_ready, a_last;
  logic [3:0]  a_index;
  logic [15:0] a_data;
  logic        b_valid, b_ready, b_last;
  logic [3:0]  b_index;
  logic [15:0] b_data;
  logic        p_valid, p_ready;
  logic [15:0] p_dataa, p_datab;
  logic [3:0]  p_index;
  logic        busy, done, err;
  logic [4:0]  match_count;

  sparse_index_merger dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .start_i       (start),
    .a_valid_i     (a_valid),
    .a_ready_o     (a_ready),
    .a_index_i     (a_index),
    .a_data_i      (a_data),
    .a_last_i      (a_last),
    .b_valid_i     (b_valid),
    .b_ready_o     (b_ready),
    .b_index_i     (b_index),
    .b_data_i      (b_data),
    .b_last_i      (b_last),
    .p_valid_o     (p_valid),
    .p_ready_i     (p_ready),
    .p_dataa_o     (p_dataa),
    .p_datab_o     (p_datab),
    .p_index_o     (p_index),
    .busy_o        (busy),
    .done_o        (done),
    .match_count_o (match_count),
    .err_o         (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int    checks = 0;
  int    passes = 0;
  el_t   qa[$];
  el_t   qb[$];
  pair_t exp_q[$];
  int    acc_cyc[$];
  int    cyc = 0;
  int    done_cnt = 0;
  int    pairs_seen = 0;
  int    pr_hold = 0;
  bit    pr_rand = 0;
  bit    bub_en = 0;
  int    exp_cnt;
  bit    exp_err;

  task automatic check(input bit ok, input string name, input string detail);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  // Stream A driver: present head at negedge, retire it if the handshake fired.
  initial begin
    a_valid = 0; a_index = 0; a_data = 0; a_last = 0;
    forever begin
      @(negedge clk);
      if (qa.size() > 0 && (!bub_en || ($urandom % 4) != 0)) begin
        a_valid = 1;
        a_index = qa[0].idx;
        a_data  = qa[0].data;
        a_last  = (qa.size() == 1);
      end else begin
        a_valid = 0;
      end
      #4;
      if (a_valid && a_ready && !reset) void'(qa.pop_front());
    end
  end

  // Stream B driver.
  initial begin
    b_valid = 0; b_index = 0; b_data = 0; b_last = 0;
    forever begin
      @(negedge clk);
      if (qb.size() > 0 && (!bub_en || ($urandom % 4) != 0)) begin
        b_valid = 1;
        b_index = qb[0].idx;
        b_data  = qb[0].data;
        b_last  = (qb.size() == 1);
      end else begin
        b_valid = 0;
      end
      #4;
      if (b_valid && b_ready && !reset) void'(qb.pop_front());
    end
  end

  // Multiplier-side ready: forced low for pr_hold cycles, else 1 or random.
  initial begin
    p_ready = 1;
    forever begin
      @(negedge clk);
      if (pr_hold > 0) begin
        p_ready = 0;
        pr_hold--;
      end else begin
        p_ready = pr_rand ? 1'($urandom % 2) : 1'b1;
      end
    end
  end

  // Monitor: scoreboard pops on accepted pairs, hold-stability, done counting.
  initial begin
    bit          stall;
    logic [3:0]  s_idx;
    logic [15:0] s_da, s_db;
    pair_t       e;
    stall = 0; s_idx = 0; s_da = 0; s_db = 0;
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      if (reset) begin
        stall = 0;
        continue;
      end
      if (done) done_cnt++;
      if (stall)
        check(p_valid && p_index == s_idx && p_dataa == s_da && p_datab == s_db, "pair_hold",
              $sformatf("got v=%0b (%h,%h,%h) need (%h,%h,%h)", p_valid, p_index, p_dataa, p_datab,
                        s_idx, s_da, s_db));
      if (p_valid && p_ready) begin
        pairs_seen++;
        acc_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check(0, "unexpected_pair", $sformatf("got (%h,%h,%h) need none", p_index, p_dataa, p_datab));
        end else begin
          e = exp_q.pop_front();
          check(p_index == e.idx && p_dataa == e.da && p_datab == e.db, "pair",
                $sformatf("got (%h,%h,%h) need (%h,%h,%h)", p_index, p_dataa, p_datab, e.idx, e.da, e.db));
        end
      end
      stall = p_valid && !p_ready;
      s_idx = p_index; s_da = p_dataa; s_db = p_datab;
    end
  end

  task automatic add_a(input int idx, input int data);
    el_t e;
    e.idx = 4'(idx); e.data = 16'(data);
    qa.push_back(e);
  endtask

  task automatic add_b(input int idx, input int data);
    el_t e;
    e.idx = 4'(idx); e.data = 16'(data);
    qb.push_back(e);
  endtask

  // Reference: a merge yields the intersection of the index sets, in A order;
  // err means some stream is not strictly increasing.
  task automatic start_merge(input string name);
    pair_t p;
    exp_err = 0;
    exp_cnt = 0;
    for (int i = 1; i < qa.size(); i++) if (qa[i].idx <= qa[i-1].idx) exp_err = 1;
    for (int i = 1; i < qb.size(); i++) if (qb[i].idx <= qb[i-1].idx) exp_err = 1;
    foreach (qa[i]) foreach (qb[j]) if (qa[i].idx == qb[j].idx) begin
      p.idx = qa[i].idx; p.da = qa[i].data; p.db = qb[j].data;
      exp_q.push_back(p);
      exp_cnt++;
    end
    if (exp_cnt > 16) exp_cnt = 16;
    done_cnt = 0;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    #4;
    check(busy == 1 && err == 0 && match_count == 0, {name, "_started"},
          $sformatf("got busy=%0b err=%0b cnt=%0d need 1,0,0", busy, err, match_count));
  endtask

  task automatic finish_merge(input string name);
    for (int k = 0; k < 3000 && done_cnt == 0; k++) @(negedge clk);
    if (done_cnt == 0) check(0, {name, "_timeout"}, "got no done pulse need one");
    repeat (3) @(negedge clk);
    #6;
    check(done_cnt == 1, {name, "_done"}, $sformatf("got %0d pulses need 1", done_cnt));
    check(match_count == 5'(exp_cnt), {name, "_count"},
          $sformatf("got %0d need %0d", match_count, exp_cnt));
    check(err == exp_err, {name, "_err"}, $sformatf("got %0b need %0b", err, exp_err));
    check(busy == 0 && exp_q.size() == 0 && qa.size() == 0 && qb.size() == 0, {name, "_drained"},
          $sformatf("got busy=%0b pend=%0d a=%0d b=%0d need 0,0,0,0", busy, exp_q.size(), qa.size(), qb.size()));
    exp_q.delete();
    qa.delete();
    qb.delete();
  endtask

  task automatic load_test1();
    add_a(1, 16'h3C00); add_a(4, 16'h4000);
    add_b(1, 16'h4200); add_b(4, 16'h4400);
  endtask

  task automatic check_reset_vals(input string name);
    check(!a_ready && !b_ready && !p_valid && p_dataa == 0 && p_datab == 0 && p_index == 0 &&
          !busy && !done && match_count == 0 && !err, name,
          $sformatf("got ar=%0b br=%0b pv=%0b pa=%h pb=%h pi=%h busy=%0b done=%0b cnt=%0d err=%0b need all 0",
                    a_ready, b_ready, p_valid, p_dataa, p_datab, p_index, busy, done, match_count, err));
  endtask

  initial begin
    int snap;
    reset = 1;
    start = 0;
    repeat (3) @(negedge clk);
    #4;
    check_reset_vals("reset_state");
    @(negedge clk);
    reset = 0;

    // 1: two matches, p_ready high
    load_test1();
    start_merge("t1");
    finish_merge("t1");

    // 2: disjoint streams, no matches
    add_a(0, 16'h1111); add_a(2, 16'h2222);
    add_b(1, 16'h3333); add_b(3, 16'h4444);
    start_merge("t2");
    finish_merge("t2");

    // 3: multiplier stalls while the first pair is held
    load_test1();
    pr_hold = 8;
    start_merge("t3");
    repeat (4) @(negedge clk);
    #6;
    check(p_valid && qa.size() == 1 && qb.size() == 1, "t3_stall_no_pop",
          $sformatf("got pv=%0b a_left=%0d b_left=%0d need 1,1,1", p_valid, qa.size(), qb.size()));
    finish_merge("t3");

    // 4: misordered A sets sticky err; next start clears it
    add_a(2, 16'h0002); add_a(1, 16'h0001);
    add_b(5, 16'h0005);
    start_merge("t4");
    finish_merge("t4");
    load_test1();
    start_merge("t4b");
    finish_merge("t4b");

    // 5: reset mid-merge after one accepted pair
    add_a(1, 16'hAAAA); add_a(4, 16'hBBBB); add_a(7, 16'hCCCC);
    add_b(1, 16'h1234); add_b(5, 16'h5678); add_b(7, 16'h9ABC);
    snap = pairs_seen;
    start_merge("t5");
    for (int k = 0; k < 200 && pairs_seen == snap; k++) @(negedge clk);
    check(pairs_seen > snap, "t5_first_pair", "got no pair need one");
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    check_reset_vals("t5_reset_vals");
    @(negedge clk);
    reset = 0;
    qa.delete(); qb.delete(); exp_q.delete();
    load_test1();
    start_merge("t5b");
    finish_merge("t5b");

    // 6: full streams, one pair per cycle
    for (int i = 0; i < 16; i++) begin
      add_a(i, $urandom);
      add_b(i, $urandom);
    end
    acc_cyc.delete();
    start_merge("t6");
    finish_merge("t6");
    check(acc_cyc.size() == 16 && acc_cyc[acc_cyc.size()-1] - acc_cyc[0] == 15, "t6_rate",
          $sformatf("got %0d pairs over %0d cycles need 16 over 15", acc_cyc.size(),
                    acc_cyc.size() > 0 ? acc_cyc[acc_cyc.size()-1] - acc_cyc[0] : -1));

    // start while busy must be ignored: pulse start again mid-merge
    add_a(3, 16'h0303); add_a(9, 16'h0909);
    add_b(3, 16'h3030); add_b(9, 16'h9090);
    pr_hold = 6;
    start_merge("busy_start");
    start = 1;
    @(negedge clk);
    start = 0;
    finish_merge("busy_start");

    // randomized merges with bubbles and random backpressure
    bub_en = 1;
    pr_rand = 1;
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 16; i++) begin
        if ($urandom % 2) add_a(i, $urandom);
        if ($urandom % 2) add_b(i, $urandom);
      end
      if (qa.size() == 0) add_a($urandom % 16, $urandom);
      if (qb.size() == 0) add_b($urandom % 16, $urandom);
      start_merge($sformatf("rnd%0d", t));
      finish_merge($sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
